// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the CLA adder and its BIST controller.
//   state_t     : BIST controller FSM states
//   CLA_W       : default adder operand width
//   golden_sum  : reference a+b+cin, returned one bit wider than the operands
//                 (callers truncate to their own W+1 bits; W must be <= 32)
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CLA_W = 4;

    function automatic logic [32:0] golden_sum(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

endpackage

// File: rtl/cla_bist_delay.sv
// -----------------------------------------------------------------------------
// cla_bist_delay
// LAT-stage shift pipe carrying a valid bit alongside a data payload. It lines
// the golden result of each issued vector up with the registered adder output.
//   clk, rst   : clock, asynchronous active-high reset (clears valids only)
//   i_flush    : synchronous clear of all in-flight valids
//   i_vld/i_dat: entry of the pipe
//   o_vld/o_dat: exit of the pipe, LAT cycles after entry
// -----------------------------------------------------------------------------
module cla_bist_delay #(
    parameter int LAT = 2,
    parameter int DW  = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_vld,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    output logic [DW-1:0] o_dat
);

    logic [LAT-1:0] r_vld;
    logic [DW-1:0]  r_dat [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        r_dat[0] <= i_dat;
        for (int i = 1; i < LAT; i++) begin
            r_dat[i] <= r_dat[i-1];
        end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_dat = r_dat[LAT-1];

endmodule

// File: rtl/cla_bist_ctrl.sv
// -----------------------------------------------------------------------------
// cla_bist_ctrl
// BIST controller for the registered CLA adder. Sweeps every {a,b,cin} vector
// into the adder, one per cycle, and checks each registered result against a
// golden sum delayed by LAT cycles.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : one-cycle pulse, accepted in IDLE or DONE
//   dut_a/b/cin      : operands to the adder (held 0 outside RUN)
//   dut_s/dut_cout   : registered adder result
//   busy             : RUN or DRAIN
//   done             : level, from sweep end until the next accepted start
//   pass             : done with zero errors
//   err_count        : saturating mismatch count
//   fail_vec/fail_res: first failing {a,b,cin} and the observed {cout,s}
// Build option: define CLA_BIST_STOP_ON_FAIL_EN to end the sweep at the first
// mismatch (in-flight checks discarded).
// -----------------------------------------------------------------------------
module cla_bist_ctrl
    import cla_pkg::*;
#(
    parameter int W     = CLA_W,
    parameter int LAT   = 2,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [W-1:0]     dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2*W:0]     fail_vec,
    output logic [W:0]       fail_res
);

    localparam int VW = 2*W + 1;
    localparam int RW = W + 1;
    localparam int DW = VW + RW;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [VW-1:0] VMAX    = '1;
    localparam logic [CW-1:0] CNT_END = CW'(LAT - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_flush;
    logic [VW-1:0]   r_vec;
    logic [CW-1:0]   r_drain_cnt;
    logic [ERR_W-1:0] r_err;
    logic [VW-1:0]   r_fail_vec;
    logic [RW-1:0]   r_fail_res;

    logic [RW-1:0]   w_push_gold;
    logic            w_chk_vld;
    logic [DW-1:0]   w_chk_dat;
    logic [VW-1:0]   w_chk_vec;
    logic [RW-1:0]   w_chk_gold;
    logic [RW-1:0]   w_obs;
    logic            w_mismatch;

    // r_vec is both the sweep counter and the register driving the adder.
    assign dut_a   = r_vec[VW-1 -: W];
    assign dut_b   = r_vec[W:1];
    assign dut_cin = r_vec[0];

    assign w_push_gold = RW'(golden_sum(32'(dut_a), 32'(dut_b), dut_cin));

    // Golden result enters the pipe in the cycle its vector is on dut_*,
    // and leaves it in the cycle the adder presents the matching result.
    cla_bist_delay #(
        .LAT (LAT),
        .DW  (DW)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_vld   (r_state == RUN),
        .i_dat   ({r_vec, w_push_gold}),
        .o_vld   (w_chk_vld),
        .o_dat   (w_chk_dat)
    );

    assign w_chk_vec  = w_chk_dat[DW-1 -: VW];
    assign w_chk_gold = w_chk_dat[RW-1:0];
    assign w_obs      = {dut_cout, dut_s};
    assign w_mismatch = w_chk_vld && (w_obs != w_chk_gold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (r_vec == VMAX) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == CNT_END) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
`ifdef CLA_BIST_STOP_ON_FAIL_EN
        // Abort on the first mismatch and drop whatever is still in flight,
        // so exactly one error is ever recorded.
        if (w_mismatch) begin
            w_state_nxt = DONE;
            w_flush     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec       <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_state_nxt == RUN) begin
                r_vec <= (r_state == RUN) ? r_vec + VW'(1) : '0;
            end else begin
                r_vec <= '0;
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + CW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // err_count is zero exactly until the first mismatch of a sweep, because
    // it saturates instead of wrapping; that marks the capture point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= '0;
            r_fail_vec <= '0;
            r_fail_res <= '0;
        end else if (w_accept) begin
            r_err      <= '0;
            r_fail_vec <= '0;
            r_fail_res <= '0;
        end else if (w_mismatch) begin
            r_err <= sat_inc(r_err);
            if (r_err == '0) begin
                r_fail_vec <= w_chk_vec;
                r_fail_res <= w_obs;
            end
        end
    end

    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign pass      = done && (r_err == '0);
    assign err_count = r_err;
    assign fail_vec  = r_fail_vec;
    assign fail_res  = r_fail_res;

endmodule
